cdb_arbiter: RTL



---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 42 ++++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus (CDB) arbiter.
// cond_exception_t : CR0 condition bits plus XER summary/overflow/carry.
// cdb_payload_t    : result payload broadcast on the CDB. The RS ID travels
//                    separately because its width is a module parameter.
package cdb_arbiter_pkg;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ca;
  } cond_exception_t;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] result_reg_addr;
    logic [DATA_W-1:0]     result;
    cond_exception_t       cr0_xer;
  } cdb_payload_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at ptr and wrapping modulo N, then grants the first
// requester it finds.
// Ports:
//   req       : per-requester request
//   ptr       : index of the highest-priority requester (0..N-1)
//   grant     : one-hot grant
//   grant_idx : index of the granted requester (0 when none)
//   any_grant : at least one requester granted
module cdb_arbiter_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  int unsigned w_idx;

  // Priority scan; the wrap is an explicit compare so non-power-of-2 N works.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = 32'(ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!any_grant && req[IW'(w_idx)]) begin
        any_grant           = 1'b1;
        grant[IW'(w_idx)]   = 1'b1;
        grant_idx           = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks at most one execution-unit result per cycle
// (round-robin) and registers it onto the CDB, with backpressure from
// writeback through cdb_ready.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   unit_valid/unit_ready : per-unit result handshake (ready = grant)
//   unit_rs_id, unit_result_reg_addr, unit_result, unit_cr0_xer : unit payloads
//   cdb_valid/cdb_ready   : CDB output handshake
//   cdb_rs_id, cdb_result_reg_addr, cdb_result, cdb_cr0_xer     : CDB payload
//   cdb_unit              : index of the unit that produced the CDB entry
//   stall_count           : only with CDB_ARB_STALL_COUNT_EN defined; saturating
//                           count of cycles a unit was waiting on a full CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned UNITS       = 4,
  parameter int unsigned RS_ID_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [UNITS-1:0]                      unit_valid,
  output logic [UNITS-1:0]                      unit_ready,
  input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]     unit_rs_id,
  input  logic [UNITS-1:0][GPR_ADDR_W-1:0]      unit_result_reg_addr,
  input  logic [UNITS-1:0][DATA_W-1:0]          unit_result,
  input  cond_exception_t [UNITS-1:0]           unit_cr0_xer,
  output logic                                  cdb_valid,
  input  logic                                  cdb_ready,
  output logic [RS_ID_WIDTH-1:0]                cdb_rs_id,
  output logic [GPR_ADDR_W-1:0]                 cdb_result_reg_addr,
  output logic [DATA_W-1:0]                     cdb_result,
  output cond_exception_t                       cdb_cr0_xer,
  output logic [$clog2(UNITS)-1:0]              cdb_unit
`ifdef CDB_ARB_STALL_COUNT_EN
  ,
  output logic [31:0]                           stall_count
`endif
);

  localparam int unsigned IDX_W = $clog2(UNITS);

  logic                   r_cdb_valid;
  logic [RS_ID_WIDTH-1:0] r_cdb_rs_id;
  cdb_payload_t           r_cdb_payload;
  logic [IDX_W-1:0]       r_cdb_unit;
  logic [IDX_W-1:0]       r_ptr;

  logic                   w_free;
  logic [UNITS-1:0]       w_grant;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_any_grant;
  logic                   w_fire;

  // Output register can take a new entry when empty or being retired now.
  assign w_free = !r_cdb_valid || cdb_ready;

  cdb_arbiter_rr_arbiter #(
    .N  (UNITS),
    .IW (IDX_W)
  ) u_rr (
    .req       (unit_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_grant (w_any_grant)
  );

  // Grant is only exposed when the register is free and not in reset.
  assign unit_ready = (w_free && !rst) ? w_grant : '0;
  assign w_fire     = w_any_grant && w_free && !rst;

  // CDB register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid   <= 1'b0;
      r_cdb_rs_id   <= '0;
      r_cdb_payload <= '0;
      r_cdb_unit    <= '0;
      r_ptr         <= '0;
    end else if (w_fire) begin
      r_cdb_valid                   <= 1'b1;
      r_cdb_rs_id                   <= unit_rs_id[w_grant_idx];
      r_cdb_payload.result_reg_addr <= unit_result_reg_addr[w_grant_idx];
      r_cdb_payload.result          <= unit_result[w_grant_idx];
      r_cdb_payload.cr0_xer         <= unit_cr0_xer[w_grant_idx];
      r_cdb_unit                    <= w_grant_idx;
      r_ptr <= (w_grant_idx == IDX_W'(UNITS - 1)) ? '0 : IDX_W'(w_grant_idx + 1'b1);
    end else if (cdb_ready) begin
      // Drain: payload keeps its last value.
      r_cdb_valid <= 1'b0;
    end
  end

  assign cdb_valid           = r_cdb_valid;
  assign cdb_rs_id           = r_cdb_rs_id;
  assign cdb_result_reg_addr = r_cdb_payload.result_reg_addr;
  assign cdb_result          = r_cdb_payload.result;
  assign cdb_cr0_xer         = r_cdb_payload.cr0_xer;
  assign cdb_unit            = r_cdb_unit;

`ifdef CDB_ARB_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  // Saturating count of cycles where some unit waits on a full CDB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (|unit_valid && !w_free && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule
